// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Iterative AES key expansion (FIPS-197) for 128/192/256-bit keys. The
//   expansion writes one 32-bit word per cycle into a 60-word store. Once
//   it is complete, round keys are read out with single-cycle latency, in
//   any order.
//
// Ports
//   clk         sole clock, all state updates on posedge
//   rst         synchronous active-high reset
//   start       request expansion of key_in/key_len (sampled when ready=1)
//   key_len     00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_in      cipher key, MSB-aligned (word 0 = key_in[255:224])
//   ready       high in IDLE and DONE
//   done        high in DONE; round-key store readable
//   cfg_err     one-cycle pulse when a start is rejected for key_len
//   num_rounds  Nr of the last accepted key (10/12/14), 0 after reset
//   rd_en       round-key read request
//   rd_idx      round index to read, 0..Nr
//   rd_valid    high exactly one cycle after rd_en
//   rd_err      qualifies rd_valid: the read was illegal
//   rd_key      {w[4r], w[4r+1], w[4r+2], w[4r+3]}, valid with rd_valid
// ---------------------------------------------------------------------------

// AES forward S-box, purely combinational table lookup.
module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is 8*(255-a) = {~a, 3'b000}.
  logic [10:0] bit_base;
  assign bit_base = {~a, 3'b000};
  assign y        = SBOX_TABLE[bit_base +: 8];
endmodule

module aes_key_schedule #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         ready,
  output logic         done,
  output logic         cfg_err,
  output logic [3:0]   num_rounds,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         rd_valid,
  output logic         rd_err,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] w [60];
  logic [5:0]  i_q;       // index of the word written this EXPAND cycle
  logic [2:0]  phase_q;   // i mod Nk, kept as a wrapping counter
  logic [7:0]  rcon_q;    // Rcon[i/Nk] for the next phase-0 word
  logic [3:0]  nk_q;      // Nk of the key being expanded
  logic [5:0]  last_q;    // Nw-1, index of the final word

  // -------------------------------------------------------------------------
  // Start decode
  // -------------------------------------------------------------------------
  logic       key_legal, accept, reject;
  logic [3:0] nk_new, nr_new;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    key_legal = 1'b0;
    nk_new    = 4'd4;
    nr_new    = 4'd10;
    unique case (key_len)
      2'b00: key_legal = 1'b1;
      2'b01: begin
        key_legal = ENABLE_192;
        nk_new    = 4'd6;
        nr_new    = 4'd12;
      end
      2'b10: begin
        key_legal = ENABLE_256;
        nk_new    = 4'd8;
        nr_new    = 4'd14;
      end
      default: key_legal = 1'b0;
    endcase
  end

  assign accept = start & ready & key_legal;
  assign reject = start & ready & ~key_legal;

  // -------------------------------------------------------------------------
  // Expansion datapath: w[i] = w[i-Nk] ^ f(w[i-1])
  // -------------------------------------------------------------------------
  logic [31:0] t, w_back, sub_in, sub_out, temp, new_word;
  logic        expand_last;

  assign t      = w[i_q - 6'd1];
  assign w_back = w[i_q - {2'b00, nk_q}];
  // RotWord is only needed on phase-0 words; other S-box uses see t directly.
  assign sub_in = (phase_q == 3'd0) ? {t[23:0], t[31:24]} : t;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    s_box u_s_box (
      .a (sub_in[8*g +: 8]),
      .y (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = t;
    if (phase_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
      temp = sub_out;
    end
  end

  assign new_word    = w_back ^ temp;
  assign expand_last = (state_q == EXPAND) && (i_q == last_q);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept)      state_d = EXPAND;
      EXPAND:     if (expand_last) state_d = DONE;
      default:                     state_d = IDLE;
    endcase
  end

  assign ready = (state_q != EXPAND);
  assign done  = (state_q == DONE);

  // -------------------------------------------------------------------------
  // Control and read registers
  // -------------------------------------------------------------------------
  logic [5:0] rd_base;
  assign rd_base = {rd_idx, 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      phase_q    <= '0;
      rcon_q     <= '0;
      nk_q       <= '0;
      last_q     <= '0;
      num_rounds <= '0;
      cfg_err    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      rd_key     <= '0;
    end else begin
      state_q <= state_d;
      cfg_err <= reject;

      if (accept) begin
        i_q        <= {2'b00, nk_new};
        phase_q    <= '0;
        rcon_q     <= 8'h01;
        nk_q       <= nk_new;
        last_q     <= {nr_new, 2'b11};   // 4*Nr+3 = Nw-1
        num_rounds <= nr_new;
      end else if (state_q == EXPAND) begin
        i_q     <= i_q + 6'd1;
        phase_q <= (phase_q == nk_q[2:0] - 3'd1) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) begin
          rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
      end

      // Reads see pre-edge done/num_rounds/store, so a read issued alongside
      // an accepted start is answered from the previous key.
      rd_valid <= rd_en;
      if (rd_en) begin
        if (done && rd_idx <= num_rounds) begin
          rd_err <= 1'b0;
          rd_key <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end else begin
          rd_err <= 1'b1;
          rd_key <= '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word store
  // -------------------------------------------------------------------------
  // NOTE: the store has no reset; its contents are never observable while
  // done=0, so clearing 60 words would cost logic and buy nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        // All eight key words are loaded regardless of Nk; the unused ones
        // are overwritten by the expansion before done can rise.
        for (int k = 0; k < 8; k++) begin
          w[k] <= key_in[255 - 32*k -: 32];
        end
      end else if (state_q == EXPAND) begin
        w[i_q] <= new_word;
      end
    end
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 Parameter ENABLE_192, default 1: 1 = key_len 2'b01 (AES-192) accepted; 0 = that mode rejected.
REQ-002 Parameter ENABLE_256, default 1: 1 = key_len 2'b10 (AES-256) accepted; 0 = that mode rejected.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request expansion of key_in/key_len; sampled only when ready=1.
REQ-006 key_len  input  2  key size: 00=128, 01=192, 10=256, 11=illegal.
REQ-007 key_in  input  256  cipher key, MSB-aligned; word 0 = key_in[255:224]. 128-bit mode uses [255:128]; 192-bit mode uses [255:64].
REQ-008 ready  output  1  high in IDLE and DONE; start is accepted only when high.
REQ-009 done  output  1  high in DONE; round-key store complete and readable.
REQ-010 cfg_err  output  1  one-cycle pulse when a start is rejected for key_len.
REQ-011 num_rounds  output  4  Nr of the last accepted key: 10/12/14; 0 after reset.
REQ-012 rd_en  input  1  round-key read request.
REQ-013 rd_idx  input  4  round index to read, 0..Nr.
REQ-014 rd_valid  output  1  high exactly one cycle after rd_en.
REQ-015 rd_err  output  1  qualifies rd_valid: the read was illegal.
REQ-016 rd_key  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}; valid with rd_valid.

Function
REQ-017 Parameters: Nk=4/6/8 and Nr=10/12/14; total words Nw=4*(Nr+1)=44/52/60; word store of 60x32 bits.
REQ-018 FSM states: IDLE, EXPAND, DONE.
REQ-019 Start acceptance in IDLE or DONE with legal key_len:
- w[0..Nk-1] are loaded from key_in.
- The word counter i is set to Nk.
- num_rounds is updated.
- done is cleared.
- The next state is EXPAND.
REQ-020 Illegal start (key_len=11, or a disabled mode):
- cfg_err pulses for one cycle.
- State, store, num_rounds and done are unchanged.
REQ-021 EXPAND writes exactly one word per cycle: w[i] = w[i-Nk] ^ temp, with temp derived from t = w[i-1] as follows.
- If i mod Nk = 0: temp = SubWord(RotWord(t)) ^ {Rcon[i/Nk], 24'h0}.
- Else if Nk = 8 and i mod 8 = 4: temp = SubWord(t).
- Otherwise: temp = t.
REQ-022 i mod Nk is tracked by a wrapping phase counter (no divider).
REQ-023 Rcon advances by GF(2^8) xtime from 8'h01: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
REQ-024 SubWord uses four s_box instances.
REQ-025 After writing w[Nw-1] the FSM enters DONE. done rises exactly Nw-Nk = 40/46/52 cycles after the start-accept edge.
REQ-026 start while in EXPAND (ready=0) is ignored; no error is raised.
REQ-027 Reads are single-cycle latency.
- rd_en at edge E gives rd_valid=1 after E.
- If done=1 and rd_idx<=num_rounds: rd_err=0 and rd_key = round key rd_idx.
- Otherwise: rd_err=1 and rd_key=0.
REQ-028 rd_key holds its last value while rd_valid=0.
REQ-029 Reads in any order are legal (forward for encrypt, reverse for decrypt).
REQ-030 Back-to-back reads sustain one per cycle.
REQ-031 A read in the cycle a new start is accepted is evaluated against pre-start state.
REQ-032 A new start from DONE overwrites the store. Old keys are unreadable from the acceptance edge onward, because done=0.

Reset
REQ-033 rst=1 at a posedge:
- State = IDLE.
- ready=1; done=0; cfg_err=0; num_rounds=0.
- rd_valid=0; rd_err=0; rd_key=0.
- i, phase and Rcon registers are cleared.
REQ-034 Word-store contents after reset are don't-care; they are unobservable while done=0.
REQ-035 Reset during EXPAND aborts the expansion. The next start begins a fresh expansion.
REQ-036 Reset has priority over start and rd_en in the same cycle.

Verification
REQ-037 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start:
- done rises 40 cycles later.
- rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
- rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-038 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
- done after 46 cycles.
- num_rounds=12.
- rd_idx=12 -> e98ba06f448c773c8ecc720401002202.
REQ-039 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
- done after 52 cycles.
- rd_idx=14 -> fe4890d1e6188d0b046df344706c631e.
- rd_idx=0 -> 603deb1015ca71be2b73aef0857d7781.
REQ-040 Error cases:
- key_len=11 -> cfg_err pulse; ready stays 1; done unchanged.
- ENABLE_256=0 with key_len=10 -> cfg_err pulse.
- After the AES-128 run, rd_idx=11 -> rd_err=1, rd_key=0.
REQ-041 Reset and read ordering:
- Assert rst at cycle 20 of an AES-256 expansion -> done=0 and ready=1 next cycle.
- Restart with the AES-128 key -> round-10 key matches REQ-037.
- Reads of idx 10..0 in consecutive cycles match FIPS-197 A.1.
